// File: rtl/dnn_train_seq.sv
// Training-run sequencer: steps forward / backward / update over N_SAMPLES
// samples (forward only in test mode) and accumulates a saturating cost.
module dnn_train_seq #(
    parameter int N_SAMPLES = 4,
    parameter int ADDR_W    = 2
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              mode_test,
    output logic              ready,
    output logic              done,
    output logic [31:0]       out_cosf,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              fwd_start,
    input  logic              fwd_done,
    output logic              bwd_start,
    input  logic              bwd_done,
    output logic              upd_start,
    input  logic              upd_done,
    input  logic              cost_valid,
    input  logic [31:0]       cost_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_FWDW, S_BWD, S_BWDW, S_UPD, S_UPDW, S_NEXT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    state_t            state_q, state_d;
    logic              start_dly_q, start_dly_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic [31:0]       acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              fwd_start_q, fwd_start_d;
    logic              bwd_start_q, bwd_start_d;
    logic              upd_start_q, upd_start_d;
    logic              start_acc;
    logic [32:0]       sum;

    always_comb begin
        state_d     = state_q;
        start_dly_d = start;
        mode_d      = mode_q;
        done_d      = done_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        start_acc   = start & ~start_dly_q & (state_q == S_IDLE);
        sum         = {1'b0, acc_q} + {1'b0, cost_in};

        case (state_q)
            S_IDLE: if (start_acc) begin
                state_d = S_FWD;
                mode_d  = mode_test;
                addr_d  = '0;
                done_d  = 1'b0;
            end
            S_FWD:  state_d = S_FWDW;
            S_FWDW: if (fwd_done) state_d = mode_q ? S_NEXT : S_BWD;
            S_BWD:  state_d = S_BWDW;
            S_BWDW: if (bwd_done) state_d = S_UPD;
            S_UPD:  state_d = S_UPDW;
            S_UPDW: if (upd_done) state_d = S_NEXT;
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FWD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clearing on an accepted start takes priority over a coincident cost.
        if (start_acc)
            acc_d = '0;
        else if (cost_valid && state_q != S_IDLE)
            acc_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

        // Moore outputs registered from the next state so they align with state_q.
        ready_d     = (state_d == S_IDLE);
        fwd_start_d = (state_d == S_FWD);
        bwd_start_d = (state_d == S_BWD);
        upd_start_d = (state_d == S_UPD);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b1;
            fwd_start_q <= 1'b0;
            bwd_start_q <= 1'b0;
            upd_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start_dly_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            ready_q     <= ready_d;
            fwd_start_q <= fwd_start_d;
            bwd_start_q <= bwd_start_d;
            upd_start_q <= upd_start_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign out_cosf    = acc_q;
    assign sample_addr = addr_q;
    assign fwd_start   = fwd_start_q;
    assign bwd_start   = bwd_start_q;
    assign upd_start   = upd_start_q;

endmodule

// File: tb/tb_dnn_train_seq.sv
// Directed bench for dnn_train_seq: done-responders with programmable latency
// drive the handshakes; each task checks its own scenario.
module tb_dnn_train_seq;

    localparam int ADDR_W = 2;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              start = 1'b0;
    logic              mode_test = 1'b0;
    logic              ready, done;
    logic [31:0]       out_cosf;
    logic [ADDR_W-1:0] sample_addr;
    logic              fwd_start, bwd_start, upd_start;
    wire               fwd_done, bwd_done, upd_done, cost_valid;
    wire  [31:0]       cost_in;

    logic        fwd_fire = 0, bwd_fire = 0, upd_fire = 0;
    logic        upd_stray = 0, cost_en = 0, cost_force = 0;
    logic [31:0] cost_val = 0;
    int          fl = 1, bl = 1, ul = 1;
    int          fc = 0, bc = 0, uc = 0;

    assign fwd_done   = fwd_fire;
    assign bwd_done   = bwd_fire;
    assign upd_done   = upd_fire | upd_stray;
    assign cost_valid = (fwd_fire & cost_en) | cost_force;
    assign cost_in    = cost_val;

    int tests = 0, fails = 0;

    dnn_train_seq #(.N_SAMPLES(4), .ADDR_W(ADDR_W)) dut (
        .aclk(aclk), .areset(areset), .start(start), .mode_test(mode_test),
        .ready(ready), .done(done), .out_cosf(out_cosf), .sample_addr(sample_addr),
        .fwd_start(fwd_start), .fwd_done(fwd_done),
        .bwd_start(bwd_start), .bwd_done(bwd_done),
        .upd_start(upd_start), .upd_done(upd_done),
        .cost_valid(cost_valid), .cost_in(cost_in)
    );

    always #5 aclk = ~aclk;

    // Latency L: done is high during the L-th cycle after the start pulse cycle.
    always @(negedge aclk) begin
        fwd_fire = 0; bwd_fire = 0; upd_fire = 0;
        if (fc > 0) begin fc--; fwd_fire = (fc == 0); end
        if (bc > 0) begin bc--; bwd_fire = (bc == 0); end
        if (uc > 0) begin uc--; upd_fire = (uc == 0); end
        if (fwd_start) fc = fl;
        if (bwd_start) bc = bl;
        if (upd_start) uc = ul;
    end

    // Per-run observations
    int          cyc, nf, nb, nu;
    logic        rdy1, fs1, done1, rdy_end;
    logic [31:0] cosf1;
    logic [ADDR_W-1:0] addr_log [0:7];
    logic        ust_log [0:299];

    task automatic do_run(input bit mt, input int hold, input bit mid_edge,
                          input bit cost_at_start, input int abort_cyc);
        @(negedge aclk);
        mode_test = mt; start = 1'b1;
        if (cost_at_start) cost_force = 1'b1;
        cyc = 0; nf = 0; nb = 0; nu = 0; rdy_end = 0;
        while (cyc < 299) begin
            @(negedge aclk);
            cyc++;
            cost_force = 1'b0;
            if (mid_edge && cyc == 10) start = 1'b1;
            else if (cyc >= hold) start = 1'b0;
            if (cyc == 1) begin
                rdy1 = ready; fs1 = fwd_start; done1 = done; cosf1 = out_cosf;
            end
            ust_log[cyc] = upd_start;
            if (fwd_start) begin
                if (nf < 8) addr_log[nf] = sample_addr;
                nf++;
            end
            if (bwd_start) nb++;
            if (upd_start) nu++;
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                areset = 1'b1;
                break;
            end
            if (done) begin
                rdy_end = ready;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (out_cosf !== 32'd0) begin fails++; $display("FAIL reset_cosf got %0d exp 0", out_cosf); end
        tests++; if (sample_addr !== '0) begin fails++; $display("FAIL reset_addr got %0d exp 0", sample_addr); end
        tests++; if ({fwd_start, bwd_start, upd_start} !== 3'b000) begin
            fails++; $display("FAIL reset_starts got %b exp 000", {fwd_start, bwd_start, upd_start}); end
    endtask

    task automatic test_train();
        fl = 1; bl = 1; ul = 1; cost_en = 1; cost_val = 32'd5;
        do_run(1'b0, 1, 1'b0, 1'b0, 0);
        tests++; if (rdy1 !== 1'b0 || fs1 !== 1'b1) begin
            fails++; $display("FAIL train_first_cycle got ready=%b fwd_start=%b exp 0/1", rdy1, fs1); end
        tests++; if (cyc !== 29) begin fails++; $display("FAIL train_done_latency got %0d exp 29", cyc); end
        tests++; if (rdy_end !== 1'b1) begin fails++; $display("FAIL train_ready_with_done got %b exp 1", rdy_end); end
        tests++; if (nf !== 4 || nb !== 4 || nu !== 4) begin
            fails++; $display("FAIL train_pulse_counts got %0d/%0d/%0d exp 4/4/4", nf, nb, nu); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (addr_log[i] !== ADDR_W'(i)) begin
                fails++; $display("FAIL train_addr%0d got %0d exp %0d", i, addr_log[i], i); end
        end
        tests++; if (out_cosf !== 32'd20) begin fails++; $display("FAIL train_cosf got %0d exp 20", out_cosf); end
    endtask

    task automatic test_test_mode();
        cost_val = 32'd100;
        do_run(1'b1, 1, 1'b0, 1'b0, 0);
        tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL tmode_done_cleared got %b exp 0", done1); end
        tests++; if (cyc !== 13) begin fails++; $display("FAIL tmode_done_latency got %0d exp 13", cyc); end
        tests++; if (nf !== 4 || nb !== 0 || nu !== 0) begin
            fails++; $display("FAIL tmode_pulse_counts got %0d/%0d/%0d exp 4/0/0", nf, nb, nu); end
        tests++; if (out_cosf !== 32'd400) begin fails++; $display("FAIL tmode_cosf got %0d exp 400", out_cosf); end
        cost_val = 32'd5; cost_force = 1'b1;
        repeat (2) @(negedge aclk);
        cost_force = 1'b0;
        @(negedge aclk);
        tests++; if (out_cosf !== 32'd400) begin fails++; $display("FAIL idle_cost_ignored got %0d exp 400", out_cosf); end
    endtask

    task automatic test_back_to_back();
        int extra;
        cost_val = 32'd7;
        do_run(1'b0, 3, 1'b1, 1'b0, 0);
        tests++; if (cyc !== 29 || nf !== 4) begin
            fails++; $display("FAIL b2b_single_run got cycles=%0d fwd=%0d exp 29/4", cyc, nf); end
        tests++; if (out_cosf !== 32'd28) begin fails++; $display("FAIL b2b_cosf got %0d exp 28", out_cosf); end
        extra = 0;
        repeat (6) begin @(negedge aclk); if (fwd_start || !ready) extra++; end
        tests++; if (extra !== 0) begin fails++; $display("FAIL b2b_no_rerun got %0d busy cycles exp 0", extra); end
    endtask

    task automatic test_saturation();
        cost_val = 32'hF000_0000;
        do_run(1'b1, 1, 1'b0, 1'b1, 0);
        tests++; if (done1 !== 1'b0 || cosf1 !== 32'd0) begin
            fails++; $display("FAIL sat_clear got done=%b cosf=%h exp 0/00000000", done1, cosf1); end
        tests++; if (out_cosf !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL sat_value got %h exp ffffffff", out_cosf); end
    endtask

    task automatic test_delays();
        fl = 3; bl = 11; ul = 1; cost_en = 0;
        fork
            begin
                repeat (3) @(negedge aclk);
                upd_stray = 1'b1;
                @(negedge aclk);
                upd_stray = 1'b0;
            end
        join_none
        do_run(1'b0, 1, 1'b0, 1'b0, 0);
        tests++; if (cyc !== 77) begin fails++; $display("FAIL delay_latency got %0d exp 77", cyc); end
        tests++; if (ust_log[16] !== 1'b0 || ust_log[17] !== 1'b1) begin
            fails++; $display("FAIL delay_upd_hold got c16=%b c17=%b exp 0/1", ust_log[16], ust_log[17]); end
        tests++; if (nu !== 4 || nb !== 4) begin
            fails++; $display("FAIL delay_counts got bwd=%0d upd=%0d exp 4/4", nb, nu); end
    endtask

    task automatic test_reset_mid();
        fl = 1; bl = 3; ul = 1; cost_en = 1; cost_val = 32'd9;
        do_run(1'b0, 1, 1'b0, 1'b0, 22);
        @(negedge aclk);
        areset = 1'b0;
        tests++; if (nf !== 3) begin fails++; $display("FAIL rst_mid_sample got %0d fwd pulses exp 3", nf); end
        tests++; if (ready !== 1'b1 || done !== 1'b0 || out_cosf !== 32'd0 || sample_addr !== '0) begin
            fails++; $display("FAIL rst_mid_state got ready=%b done=%b cosf=%0d addr=%0d exp 1/0/0/0",
                              ready, done, out_cosf, sample_addr); end
        repeat (4) @(negedge aclk);
        tests++; if (ready !== 1'b1 || bwd_start !== 1'b0 || upd_start !== 1'b0) begin
            fails++; $display("FAIL rst_late_done got ready=%b bwd=%b upd=%b exp 1/0/0", ready, bwd_start, upd_start); end
        bl = 1;
        do_run(1'b0, 1, 1'b0, 1'b0, 0);
        tests++; if (cyc !== 29 || nf !== 4 || nu !== 4) begin
            fails++; $display("FAIL rst_rerun got cycles=%0d fwd=%0d upd=%0d exp 29/4/4", cyc, nf, nu); end
        tests++; if (out_cosf !== 32'd36) begin fails++; $display("FAIL rst_rerun_cosf got %0d exp 36", out_cosf); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_test_mode();
        test_back_to_back();
        test_saturation();
        test_delays();
        test_reset_mid();
        repeat (2) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dnn_train_seq.md
# dnn_train_seq

Sequencer between the AXI control register block and the DNN datapath. It turns the software start request into an ordered run over `N_SAMPLES` training samples: forward, backward and weight update per sample, or forward only in test mode. It also accumulates the per-sample cost into `out_cosf`. Its `ready`, `done` and `out_cosf` outputs feed the control register block's read-only registers.

## Interface
- `N_SAMPLES`, default 4: samples per run, must be ≥1.
- `ADDR_W`, default 2: width of `sample_addr`, must satisfy 2^ADDR_W ≥ N_SAMPLES.
- `aclk` in 1: clock; all logic on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `start` in 1: request level from the control register block. It may stay high for several cycles; only a rising edge counts.
- `mode_test` in 1: 1 selects forward-only; sampled on the accepted start edge.
- `ready` out 1: high when idle and able to accept a start.
- `done` out 1: sticky run-complete flag.
- `out_cosf` out 32: accumulated cost, unsigned, saturating.
- `sample_addr` out ADDR_W: index of the sample being processed.
- `fwd_start` out 1: one-cycle pulse that launches the forward pass.
- `fwd_done` in 1: forward pass complete.
- `bwd_start` out 1: one-cycle pulse that launches backpropagation.
- `bwd_done` in 1: backpropagation complete.
- `upd_start` out 1: one-cycle pulse that launches the weight update.
- `upd_done` in 1: weight update complete.
- `cost_valid` in 1: `cost_in` is valid this cycle.
- `cost_in` in 32: unsigned per-sample cost.

## Operation
- Edge detect: register `start_d <= start`. `start_acc = start & ~start_d & (state==S_IDLE)`. Edges seen outside S_IDLE are dropped, not queued.
- FSM states: S_IDLE, S_FWD, S_FWDW, S_BWD, S_BWDW, S_UPD, S_UPDW, S_NEXT.
- S_IDLE → S_FWD on `start_acc`. In the same cycle:
  - latch `mode_test` into `mode_r`
  - set `sample_addr` to 0
  - clear the accumulator to 0
  - clear `done`
- S_FWD: `fwd_start`=1. Go to S_FWDW unconditionally.
- S_FWDW: wait for `fwd_done`. On `fwd_done`, go to S_NEXT if `mode_r`=1, else to S_BWD.
- S_BWD: `bwd_start`=1, then S_BWDW. S_BWDW waits for `bwd_done`, then goes to S_UPD.
- S_UPD: `upd_start`=1, then S_UPDW. S_UPDW waits for `upd_done`, then goes to S_NEXT.
- S_NEXT, last sample (`sample_addr == N_SAMPLES-1`): go to S_IDLE and set `done` to 1. `sample_addr` holds its value.
- S_NEXT, otherwise: increment `sample_addr` and go to S_FWD.
- `done` stays high until the next accepted start or a reset.
- `*_done` inputs are only sampled in the matching wait state. Outside it they are ignored.
- Cost accumulation:
  - When `cost_valid`=1 in any state other than S_IDLE: `acc <= (acc + cost_in)`, computed 33 bits wide. If bit 32 is set, the result saturates to 32'hFFFFFFFF.
  - `cost_valid` in S_IDLE is ignored.
  - If `cost_valid` coincides with `start_acc`, the clear wins and the cost is dropped.
  - `out_cosf = acc`, live at all times and stable in S_IDLE.
- Moore outputs: `ready = (state==S_IDLE)`, `fwd_start = (state==S_FWD)`, and likewise for `bwd_start` and `upd_start`.
- Reset mid-run: the next state is S_IDLE; any later `*_done` and `cost_valid` belonging to the aborted run are ignored.

## Timing
- Reset values: state S_IDLE, `ready`=1, `done`=0, `out_cosf`=0, `sample_addr`=0, all `*_start`=0, `start_d`=0, `mode_r`=0.
- Start edge first sampled high at edge T: `ready` is 0 and `fwd_start` is 1 in cycle T+1.
- If every `*_done` arrives in the first wait-state cycle:
  - a sample takes 7 cycles in train mode and 3 cycles in test mode;
  - `done` rises 1 + 7·N_SAMPLES cycles after T in train mode, or 1 + 3·N_SAMPLES in test mode, with the default N_SAMPLES=4 giving 29 or 13 cycles;
  - `ready` rises in the same cycle as `done`.
- Each `*_start` pulse lasts exactly one cycle, and there is one pulse per phase per sample.
- `*_done` must not arrive before the cycle after its `*_start`; a `*_done` that arrives early is ignored.

## Test plan
- Reset, then a train run with N_SAMPLES=4 and 1-cycle done responders:
  - `fwd_start`, `bwd_start` and `upd_start` each pulse 4 times;
  - `sample_addr` steps 0,1,2,3;
  - `done`=1 and `ready`=1 appear 29 cycles after the start edge.
- Test mode (`mode_test`=1) with `cost_in`=100 each sample: `bwd_start` and `upd_start` never pulse, `done` rises after 13 cycles, `out_cosf`=400.
- Hold `start` high for 3 cycles, and give a second rising edge mid-run: exactly one run occurs. A new edge after `done` clears `done` and `out_cosf` to 0.
- Saturation: `cost_in`=32'hF0000000 on two samples gives `out_cosf`=32'hFFFFFFFF, not a wrapped value. A cost in S_IDLE leaves `out_cosf` unchanged.
- Delays and stray dones: `bwd_done` delayed 10 cycles makes the FSM hold in S_BWDW with `upd_start`=0. A stray `upd_done` during S_FWDW causes no state change.
- Reset asserted in S_BWDW during sample 2:
  - the next cycle shows `ready`=1, `done`=0, `out_cosf`=0 and `sample_addr`=0;
  - a late `bwd_done` is ignored;
  - a subsequent start runs cleanly.
